// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl shared types: FSM state encoding and counter width derivation.
// Used by scan_ctrl_if, scan_cell and scan_ctrl via import scan_ctrl_pkg::*.
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    UPDATE  = 2'd3
  } state_e;

  // Counter indexes SHIFT cycles 0..width-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/scan_ctrl_if.sv
// scan_ctrl host bus: start/capture/serial-in toward the sequencer and
// busy/so/shift_en/update/done back to the host. loop_in exists only
// when SCAN_CTRL_LOOPBACK_EN is defined.
interface scan_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_in;
  logic [WIDTH-1:0] cap_data_in;
  logic             si_in;
`ifdef SCAN_CTRL_LOOPBACK_EN
  logic             loop_in;
`endif
  logic             busy_out;
  logic             so_out;
  logic             shift_en_out;
  logic [WIDTH-1:0] upd_data_out;
  logic             done_out;

  modport master (
`ifdef SCAN_CTRL_LOOPBACK_EN
    output loop_in,
`endif
    output start_in, cap_data_in, si_in,
    input  busy_out, so_out, shift_en_out,
    input  upd_data_out, done_out
  );

  modport slave (
`ifdef SCAN_CTRL_LOOPBACK_EN
    input  loop_in,
`endif
    input  start_in, cap_data_in, si_in,
    output busy_out, so_out, shift_en_out,
    output upd_data_out, done_out
  );
endinterface

// File: rtl/scan_cell.sv
// One scan chain bit: hold / capture / shift mux into an async-reset flop.
// Ports: clk_in, n_rst_in, cap_in, shift_in, cap_d_in, shift_d_in, q_out.
module scan_cell (
  input  logic clk_in,
  input  logic n_rst_in,
  input  logic cap_in,
  input  logic shift_in,
  input  logic cap_d_in,
  input  logic shift_d_in,
  output logic q_out
);
  logic r_q;
  logic w_d;

  always_comb begin
    w_d = r_q;
    unique case (1'b1)
      cap_in:   w_d = cap_d_in;
      shift_in: w_d = shift_d_in;
      default:  w_d = r_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) r_q <= 1'b0;
    else           r_q <= w_d;
  end

  assign q_out = r_q;
endmodule

// File: rtl/scan_ctrl.sv
// Capture -> serial shift (LSB out, MSB in) -> update sequencer for a
// WIDTH-bit flop chain. Ports: clk_in, n_rst_in, bus (scan_ctrl_if.slave).
// Optional SCAN_CTRL_LOOPBACK_EN: bus.loop_in rotates the chain.
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk_in,
  input  logic       n_rst_in,
  scan_ctrl_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);

  state_e           r_state;
  state_e           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_chain;
  logic [WIDTH-1:0] r_upd;
  logic             r_done;
  logic             w_cap;
  logic             w_shift;
  logic             w_upd;
  logic             w_busy;
  logic             w_last;
  logic             w_sin;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start_in) w_next = CAPTURE;
      CAPTURE: w_next = SHIFT;
      SHIFT:   if (w_last) w_next = UPDATE;
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cap   = 1'b0;
    w_shift = 1'b0;
    w_upd   = 1'b0;
    w_busy  = 1'b1;
    unique case (r_state)
      IDLE:    w_busy  = 1'b0;
      CAPTURE: w_cap   = 1'b1;
      SHIFT:   w_shift = 1'b1;
      UPDATE:  w_upd   = 1'b1;
      default: w_busy  = 1'b0;
    endcase
  end

  // Wrap to 0 on the last shift so the count never passes WIDTH-1.
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in)    r_cnt <= '0;
    else if (w_cap)   r_cnt <= '0;
    else if (w_shift) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
  end

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      r_upd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_upd;
      if (w_upd) r_upd <= w_chain;
    end
  end

`ifdef SCAN_CTRL_LOOPBACK_EN
  assign w_sin = bus.loop_in ? w_chain[0] : bus.si_in;
`else
  assign w_sin = bus.si_in;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_d_sh;
    if (i == WIDTH - 1) begin : g_top
      assign w_d_sh = w_sin;
    end else begin : g_mid
      assign w_d_sh = w_chain[i+1];
    end
    scan_cell u_cell (
      .clk_in     (clk_in),
      .n_rst_in   (n_rst_in),
      .cap_in     (w_cap),
      .shift_in   (w_shift),
      .cap_d_in   (bus.cap_data_in[i]),
      .shift_d_in (w_d_sh),
      .q_out      (w_chain[i])
    );
  end

  assign bus.busy_out     = w_busy;
  assign bus.shift_en_out = w_shift;
  assign bus.so_out       = w_chain[0];
  assign bus.upd_data_out = r_upd;
  assign bus.done_out     = r_done;
endmodule

// File: tb/tb_scan_ctrl.sv
// Testbench for scan_ctrl: WIDTH=8 and WIDTH=2 instances, queue scoreboard
// of expected so_out bits and upd_data_out values checked by monitors.
module tb_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done8_cnt = 0;
  int   done2_cnt = 0;
  int   sh2_cnt = 0;

  logic       so8_q[$];
  logic [7:0] upd8_q[$];
  logic       so2_q[$];
  logic [1:0] upd2_q[$];
  logic       e8s;
  logic [7:0] e8u;
  logic       e2s;
  logic [1:0] e2u;

  scan_ctrl_if #(.WIDTH(8)) b8 ();
  scan_ctrl_if #(.WIDTH(2)) b2 ();

  scan_ctrl #(.WIDTH(8)) dut8 (
    .clk_in   (clk),
    .n_rst_in (rst_n),
    .bus      (b8.slave)
  );

  scan_ctrl #(.WIDTH(2)) dut2 (
    .clk_in   (clk),
    .n_rst_in (rst_n),
    .bus      (b2.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (b8.shift_en_out) begin
      total++;
      if (so8_q.size() == 0) begin
        bad++;
        $display("FAIL so8: unexpected shift, so=%0b", b8.so_out);
      end else begin
        e8s = so8_q.pop_front();
        if (b8.so_out !== e8s) begin
          bad++;
          $display("FAIL so8: got %0b want %0b", b8.so_out, e8s);
        end
      end
    end
    if (b8.done_out) begin
      done8_cnt++;
      total++;
      if (upd8_q.size() == 0) begin
        bad++;
        $display("FAIL upd8: unexpected done, upd=%h", b8.upd_data_out);
      end else begin
        e8u = upd8_q.pop_front();
        if (b8.upd_data_out !== e8u) begin
          bad++;
          $display("FAIL upd8: got %h want %h", b8.upd_data_out, e8u);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b2.shift_en_out) begin
      sh2_cnt++;
      total++;
      if (so2_q.size() == 0) begin
        bad++;
        $display("FAIL so2: unexpected shift, so=%0b", b2.so_out);
      end else begin
        e2s = so2_q.pop_front();
        if (b2.so_out !== e2s) begin
          bad++;
          $display("FAIL so2: got %0b want %0b", b2.so_out, e2s);
        end
      end
    end
    if (b2.done_out) begin
      done2_cnt++;
      total++;
      if (upd2_q.size() == 0) begin
        bad++;
        $display("FAIL upd2: unexpected done, upd=%b", b2.upd_data_out);
      end else begin
        e2u = upd2_q.pop_front();
        if (b2.upd_data_out !== e2u) begin
          bad++;
          $display("FAIL upd2: got %b want %b", b2.upd_data_out, e2u);
        end
      end
    end
  end

  task automatic run8(input logic [7:0] cap, input logic [7:0] sib,
                      input logic lp, input bit poke);
    int e0;
    int d0;
    bit got;
    for (int k = 0; k < 8; k++) so8_q.push_back(cap[k]);
    upd8_q.push_back(lp ? cap : sib);
    d0 = done8_cnt;
    @(posedge clk); #1;
    b8.cap_data_in = cap;
    b8.start_in = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    b8.start_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      b8.si_in = sib[k];
      b8.start_in = poke && (k == 3);
    end
    b8.start_in = 1'b0;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (b8.done_out) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done8_timeout: no done for cap=%h", cap);
    end else if (cyc - e0 != 10) begin
      bad++;
      $display("FAIL done8_latency: got %0d want 10", cyc - e0);
    end
    @(negedge clk);
    total++;
    if (b8.done_out !== 1'b0 || done8_cnt != d0 + 1) begin
      bad++;
      $display("FAIL done8_pulse: done=%0b pulses=%0d want 0/1",
               b8.done_out, done8_cnt - d0);
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (b8.busy_out !== 1'b0) begin
      bad++; $display("FAIL rst_busy: got %0b want 0", b8.busy_out);
    end
    total++;
    if (b8.shift_en_out !== 1'b0) begin
      bad++; $display("FAIL rst_shen: got %0b want 0", b8.shift_en_out);
    end
    total++;
    if (b8.so_out !== 1'b0) begin
      bad++; $display("FAIL rst_so: got %0b want 0", b8.so_out);
    end
    total++;
    if (b8.upd_data_out !== 8'h00) begin
      bad++; $display("FAIL rst_upd: got %h want 00", b8.upd_data_out);
    end
    total++;
    if (b8.done_out !== 1'b0) begin
      bad++; $display("FAIL rst_done: got %0b want 0", b8.done_out);
    end
    total++;
    if (b2.upd_data_out !== 2'b00 || b2.busy_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_w2: upd=%b busy=%0b want 00/0",
               b2.upd_data_out, b2.busy_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (b8.busy_out !== 1'b0) begin
      bad++; $display("FAIL idle_busy: got %0b want 0", b8.busy_out);
    end
  endtask

  task automatic test_a5;
    b8.si_in = 1'b0;
    run8(8'hA5, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_ff3c;
    run8(8'hFF, 8'h3C, 1'b0, 1'b0);
    total++;
    if (b8.upd_data_out !== 8'h3C) begin
      bad++; $display("FAIL hold_3c: got %h want 3c", b8.upd_data_out);
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    for (int k = 0; k < 8; k++) so8_q.push_back(1'b1);
    upd8_q.push_back(8'h00);
    d0 = done8_cnt;
    @(posedge clk); #1;
    b8.cap_data_in = 8'hFF;
    b8.si_in = 1'b0;
    b8.start_in = 1'b1;
    @(posedge clk); #1;
    b8.start_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    so8_q.delete();
    upd8_q.delete();
    #1;
    total++;
    if (b8.busy_out !== 1'b0 || b8.shift_en_out !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ctl: busy=%0b shen=%0b want 0/0",
               b8.busy_out, b8.shift_en_out);
    end
    total++;
    if (b8.so_out !== 1'b0) begin
      bad++; $display("FAIL midrst_so: got %0b want 0", b8.so_out);
    end
    total++;
    if (b8.upd_data_out !== 8'h00 || b8.done_out !== 1'b0) begin
      bad++;
      $display("FAIL midrst_upd: upd=%h done=%0b want 00/0",
               b8.upd_data_out, b8.done_out);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done8_cnt != d0 || b8.busy_out !== 1'b0) begin
      bad++;
      $display("FAIL midrst_nodone: pulses=%0d busy=%0b want 0/0",
               done8_cnt - d0, b8.busy_out);
    end
    run8(8'h96, 8'h69, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start;
    int d0;
    d0 = done8_cnt;
    run8(8'h3C, 8'hC5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (done8_cnt != d0 + 1 || b8.busy_out !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start: pulses=%0d busy=%0b want 1/0",
               done8_cnt - d0, b8.busy_out);
    end
  endtask

  task automatic test_back_to_back;
    int nd;
    int idle;
    int t[3];
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 8; k++) so8_q.push_back((k % 3) == 0);
      upd8_q.push_back(8'h00);
    end
    nd = 0;
    idle = 0;
    t = '{0, 0, 0};
    b8.si_in = 1'b0;
    b8.cap_data_in = 8'h49;
    @(posedge clk); #1;
    b8.start_in = 1'b1;
    for (int c = 0; c < 60 && nd < 3; c++) begin
      @(negedge clk);
      if (b8.done_out) begin
        t[nd] = cyc;
        nd++;
        if (nd == 3) b8.start_in = 1'b0;
      end
      if (!b8.busy_out && nd >= 1 && nd < 3) idle++;
    end
    b8.start_in = 1'b0;
    total++;
    if (nd != 3) begin
      bad++; $display("FAIL b2b_count: got %0d want 3", nd);
    end
    total++;
    if (t[1] - t[0] != 11 || t[2] - t[1] != 11) begin
      bad++;
      $display("FAIL b2b_period: got %0d,%0d want 11,11",
               t[1] - t[0], t[2] - t[1]);
    end
    total++;
    if (idle != 2) begin
      bad++; $display("FAIL b2b_idle: got %0d want 2", idle);
    end
    repeat (3) @(negedge clk);
    total++;
    if (b8.busy_out !== 1'b0) begin
      bad++; $display("FAIL b2b_stop: busy=%0b want 0", b8.busy_out);
    end
  endtask

  task automatic test_w2;
    int e0;
    int s0;
    bit got;
    so2_q.push_back(1'b0);
    so2_q.push_back(1'b1);
    upd2_q.push_back(2'b11);
    s0 = sh2_cnt;
    @(posedge clk); #1;
    b2.cap_data_in = 2'b10;
    b2.si_in = 1'b1;
    b2.start_in = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    b2.start_in = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (b2.done_out) got = 1;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL w2_timeout: no done");
    end else if (cyc - e0 != 4) begin
      bad++; $display("FAIL w2_latency: got %0d want 4", cyc - e0);
    end
    total++;
    if (sh2_cnt - s0 != 2) begin
      bad++; $display("FAIL w2_shifts: got %0d want 2", sh2_cnt - s0);
    end
  endtask

`ifdef SCAN_CTRL_LOOPBACK_EN
  task automatic test_loopback;
    b8.loop_in = 1'b1;
    run8(8'h5A, 8'h55, 1'b1, 1'b0);
    b8.loop_in = 1'b0;
  endtask
`endif

  initial begin
    b8.start_in = 1'b0;
    b8.cap_data_in = '0;
    b8.si_in = 1'b0;
    b2.start_in = 1'b0;
    b2.cap_data_in = '0;
    b2.si_in = 1'b0;
`ifdef SCAN_CTRL_LOOPBACK_EN
    b8.loop_in = 1'b0;
    b2.loop_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    test_reset();
    test_a5();
    test_ff3c();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    test_w2();
`ifdef SCAN_CTRL_LOOPBACK_EN
    test_loopback();
`endif
    repeat (4) @(negedge clk);
    total++;
    if (so8_q.size() != 0 || upd8_q.size() != 0 ||
        so2_q.size() != 0 || upd2_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: left so8=%0d upd8=%0d so2=%0d upd2=%0d want 0",
               so8_q.size(), upd8_q.size(), so2_q.size(), upd2_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scan_ctrl.md
# scan_ctrl

Sequencer for a WIDTH-bit chain of async-reset flip-flops. It runs one capture → serial-shift → update operation per start request:
- loads the chain in parallel;
- streams it out LSB first while shifting new serial data in;
- commits the final chain contents to a parallel update register.

It sits between a test or configuration host and any block whose state is accessed through a flop chain.

## Interface
- WIDTH, 8, chain length in bits (≥2).
- clk_in  input  1  clock, all state updates on rising edge.
- n_rst_in  input  1  reset, asynchronous, active-low.
- start_in  input  1  operation request, sampled only in IDLE.
- cap_data_in  input  WIDTH  parallel value loaded into chain in CAPTURE.
- si_in  input  1  serial data shifted into chain MSB during SHIFT.
- busy_out  output  1  high in CAPTURE, SHIFT, UPDATE.
- so_out  output  1  chain bit 0; valid when shift_en_out=1.
- shift_en_out  output  1  high exactly in the WIDTH SHIFT cycles.
- upd_data_out  output  WIDTH  committed chain value, registered.
- done_out  output  1  one-cycle pulse, coincident with new upd_data_out.

## Operation
- States:
  - IDLE: start_in=1 → CAPTURE; else stay.
  - CAPTURE: one cycle; chain ← cap_data_in; count ← 0; → SHIFT.
  - SHIFT: WIDTH cycles; chain ← {si_in, chain[WIDTH-1:1]}; count++. At count==WIDTH-1 → UPDATE.
  - UPDATE: one cycle; upd_data_out ← chain; done_out ← 1; → IDLE.
- Outputs by state:
  - so_out = chain[0] (combinational from chain register).
  - shift_en_out = (state==SHIFT).
  - busy_out = (state≠IDLE).
  - done_out: registered, cleared every edge except the UPDATE exit edge.
- Outside CAPTURE/SHIFT, the chain holds its value.
- start_in is ignored while busy. Requests are not queued.
- start_in=1 in the IDLE cycle where done_out=1 is accepted. Back-to-back operations have period WIDTH+3.
- Counter width: $clog2(WIDTH); it never exceeds WIDTH-1.
- n_rst_in low at any time, including mid-SHIFT, immediately forces:
  - state=IDLE, count=0, chain=0, upd_data_out=0, done_out=0;
  - therefore busy_out=0, shift_en_out=0, so_out=0.
  - No done pulse is produced for an aborted operation.

## Timing
- Reset values: every output 0.
- start_in sampled high at edge E0:
  - CAPTURE during cycle E0..E1;
  - SHIFT across E1..E1+WIDTH;
  - UPDATE across E1+WIDTH..E2+WIDTH.
- done_out and the new upd_data_out are visible after edge E0+WIDTH+2. For WIDTH=8 that is after E10.
- so_out sequence: bit k of the captured value appears in the k-th SHIFT cycle.
- After WIDTH shifts, the first si_in bit shifted occupies upd_data_out[0].

## Configuration
- SCAN_CTRL_LOOPBACK_EN:
  - Defined: adds input loop_in (1 bit). While loop_in=1, the SHIFT input is chain[0] instead of si_in, so the chain rotates and upd_data_out equals the captured value.
  - Undefined: port absent; si_in is always the shift input.

## Structure
- Package scan_ctrl_pkg holds:
  - state enum: IDLE=2'd0, CAPTURE=2'd1, SHIFT=2'd2, UPDATE=2'd3;
  - count-width localparam derivation.
- Sub-module scan_cell:
  - one chain bit: 3-way hold/capture/shift mux feeding a flop with async active-low reset;
  - instantiated WIDTH times by scan_ctrl.
- FSM, counter and update register live in scan_ctrl.

## Test plan
- Reset: drive n_rst_in low mid-SHIFT (count=4, WIDTH=8) → all outputs 0 immediately, no done_out. A later start completes a full operation normally.
- WIDTH=8, cap_data_in=8'hA5, si_in=0 → so_out = 1,0,1,0,0,1,0,1 over 8 shift_en_out cycles. upd_data_out=8'h00, done_out single pulse after E10.
- cap_data_in=8'hFF, si_in driven with bits of 8'h3C LSB first → so_out all 1s, upd_data_out=8'h3C.
- start_in pulsed during SHIFT → ignored, one done_out only. start_in held high → done_out every 11 cycles, busy_out low 1 cycle between operations.
- WIDTH=2, cap_data_in=2'b10, si_in=1 → exactly 2 SHIFT cycles, so_out 0 then 1, upd_data_out=2'b11.
- With SCAN_CTRL_LOOPBACK_EN, loop_in=1, cap_data_in=8'h5A, si_in toggling → upd_data_out=8'h5A.
